// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan encoder/decoder pair.
// Holds the active-low glyph table, the dark-digit pattern, the scan FSM
// states and small helpers for classifying the anode bus.
package ssd_pkg;

   localparam logic [6:0] SSD_BLANK = 7'h7F;

   localparam logic [15:0][6:0] SSD_GLYPHS = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef enum logic [0:0] {
      SYNC,
      COLLECT
   } scanState_t;

   // True when exactly one digit enable is driven low.
   function automatic logic isSingleDigit(input logic [7:0] anode);
      return $countones(~anode) == 1;
   endfunction

   // True when two or more digit enables are low at the same time.
   function automatic logic isMultiDigit(input logic [7:0] anode);
      return $countones(~anode) > 1;
   endfunction

   // Position of the low bit of a one-cold anode word.
   function automatic logic [2:0] digitIndex(input logic [7:0] anode);
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (!anode[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/ssd_glyph_decode.sv
// Combinational inverse of the shared glyph table: turns one active-low
// cathode pattern into a hex nibble, a dark-digit flag and an illegal flag.
module ssd_glyph_decode
   import ssd_pkg::*;
(
   input  logic [6:0] cathode,
   output logic [3:0] nibble,
   output logic       isBlank,
   output logic       illegal
);

   // Search the glyph table; anything that is neither a glyph nor fully
   // dark is reported as illegal and shown as a dark zero.
   always_comb begin
      nibble  = 4'h0;
      isBlank = 1'b0;
      illegal = 1'b1;
      if (cathode == SSD_BLANK) begin
         isBlank = 1'b1;
         illegal = 1'b0;
      end else begin
         for (int i = 0; i < 16; i++) begin
            if (cathode == SSD_GLYPHS[i]) begin
               nibble  = 4'(i);
               illegal = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/ssd_scan_decoder.sv
// Receive-side monitor for a multiplexed eight-digit seven-segment display.
// Rebuilds the displayed digits from the anode/cathode buses and publishes
// a frame once it has repeated STABLE_FRAMES times.
// Optional feature macro: SSD_DECODE_TIMEOUT_EN enables the scan watchdog
// and the scan_lost flag; without it scan_lost is held low.
module ssd_scan_decoder
   import ssd_pkg::*;
#(
   parameter int STABLE_FRAMES  = 2,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  ssdAnode,
   input  logic [6:0]  ssdCathode,
   output logic [31:0] digits,
   output logic [7:0]  blank,
   output logic        frame_valid,
   output logic        seg_err,
   output logic        anode_err,
   output logic        scan_lost
);

   localparam int STAB_W = $clog2(STABLE_FRAMES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_FRAMES);

   // Parameters below one make no sense for a stability filter or a watchdog.
   if (STABLE_FRAMES < 1 || TIMEOUT_CYCLES < 1) begin : gParamCheck
      $error("ssd_scan_decoder: STABLE_FRAMES and TIMEOUT_CYCLES must be at least 1");
   end

   scanState_t state, stateNext;

   logic [7:0]        anodeQ, anodePrev, lastAnode;
   logic [6:0]        cathodeQ;
   logic [3:0]        decNibble;
   logic              decBlank, decIllegal;
   logic              anodeValid, anodeMulti, anodeChange, captureEn;
   logic [2:0]        idx;
   logic [7:0]        seen, badMask, segErrSent;
   logic [31:0]       shadowDigits, lastDigits;
   logic [7:0]        shadowBlank, lastBlank;
   logic              lastValid, published;
   logic [STAB_W-1:0] stabCnt, stabNext;
   logic              frameBad, sameFrame, closeFrame, frameStart, publishNow;
   logic              timeout;

   // The buses come from off-chip or from another clock-agnostic driver, so
   // register them once; lastAnode remembers the most recent valid digit so
   // an inter-digit gap does not look like a new digit.
   always_ff @(posedge clk) begin
      if (reset) begin
         anodeQ    <= 8'hFF;
         anodePrev <= 8'hFF;
         lastAnode <= 8'hFF;
         cathodeQ  <= SSD_BLANK;
      end else begin
         anodeQ    <= ssdAnode;
         anodePrev <= anodeQ;
         cathodeQ  <= ssdCathode;
         if (anodeValid) lastAnode <= anodeQ;
      end
   end

   assign anodeValid  = isSingleDigit(anodeQ);
   assign anodeMulti  = isMultiDigit(anodeQ);
   assign idx         = digitIndex(anodeQ);
   assign anodeChange = anodeValid && (anodeQ != lastAnode);
   assign captureEn   = (state == COLLECT) && anodeValid && (anodeQ == anodePrev);

   ssd_glyph_decode uGlyph (
      .cathode (cathodeQ),
      .nibble  (decNibble),
      .isBlank (decBlank),
      .illegal (decIllegal)
   );

   // Scan state register.
   always_ff @(posedge clk) begin
      if (reset) state <= SYNC;
      else       state <= stateNext;
   end

   // SYNC waits for a fresh digit to anchor a frame; COLLECT closes a frame
   // when a new digit arrives after all eight were captured. A watchdog
   // expiry overrides everything and drops back to SYNC.
   always_comb begin
      stateNext  = state;
      closeFrame = 1'b0;
      frameStart = 1'b0;
      case (state)
         SYNC: begin
            if (anodeChange) begin
               stateNext  = COLLECT;
               frameStart = 1'b1;
            end
         end
         COLLECT: begin
            if (anodeChange && !anodeMulti && seen == 8'hFF) begin
               closeFrame = 1'b1;
               frameStart = 1'b1;
            end
         end
         default: stateNext = SYNC;
      endcase
      if (timeout) begin
         stateNext  = SYNC;
         closeFrame = 1'b0;
         frameStart = 1'b0;
      end
   end

   // Evaluate the frame being closed: a bad frame never matches, and a
   // matching frame bumps the saturating stability count. Publishing happens
   // once when the count first reaches the target for this content.
   always_comb begin
      frameBad  = |badMask;
      sameFrame = lastValid && !frameBad &&
                  (shadowDigits == lastDigits) && (shadowBlank == lastBlank);
      stabNext  = STAB_W'(1);
      if (sameFrame) begin
         stabNext = (stabCnt == STAB_MAX) ? stabCnt : stabCnt + STAB_W'(1);
      end
      publishNow = closeFrame && !frameBad && (stabNext == STAB_MAX) &&
                   !(sameFrame && published);
   end

   // Digit capture, frame bookkeeping and the registered outputs. Each
   // settled digit overwrites its shadow slot so the last value wins;
   // seg_err fires only on the first illegal capture of a digit per frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         seen         <= '0;
         badMask      <= '0;
         segErrSent   <= '0;
         shadowDigits <= '0;
         shadowBlank  <= 8'hFF;
         lastDigits   <= '0;
         lastBlank    <= 8'hFF;
         lastValid    <= 1'b0;
         published    <= 1'b0;
         stabCnt      <= '0;
         digits       <= '0;
         blank        <= 8'hFF;
         frame_valid  <= 1'b0;
         seg_err      <= 1'b0;
         anode_err    <= 1'b0;
      end else begin
         frame_valid <= 1'b0;
         seg_err     <= 1'b0;
         anode_err   <= anodeMulti;
         if (timeout) begin
            seen      <= '0;
            stabCnt   <= '0;
            lastValid <= 1'b0;
            published <= 1'b0;
         end else begin
            if (frameStart) begin
               seen       <= '0;
               badMask    <= '0;
               segErrSent <= '0;
            end else if (captureEn) begin
               seen[idx]                        <= 1'b1;
               shadowDigits[{idx, 2'b00} +: 4] <= decNibble;
               shadowBlank[idx]                 <= decBlank || decIllegal;
               badMask[idx]                     <= decIllegal;
               if (decIllegal && !segErrSent[idx]) begin
                  seg_err         <= 1'b1;
                  segErrSent[idx] <= 1'b1;
               end
            end
            if (closeFrame) begin
               stabCnt <= stabNext;
               if (!sameFrame) begin
                  lastDigits <= shadowDigits;
                  lastBlank  <= shadowBlank;
                  lastValid  <= !frameBad;
                  published  <= 1'b0;
               end
               if (publishNow) begin
                  digits      <= shadowDigits;
                  blank       <= shadowBlank;
                  frame_valid <= 1'b1;
                  published   <= 1'b1;
               end
            end
         end
      end
   end

`ifdef SSD_DECODE_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wdCnt;
   logic            scanLostQ;

   // Watchdog: counts cycles since the last frame close and flags a lost
   // scan when the limit is hit; the flag drops again on the next publish.
   always_ff @(posedge clk) begin
      if (reset) begin
         wdCnt     <= '0;
         scanLostQ <= 1'b0;
      end else begin
         if (timeout || closeFrame) wdCnt <= '0;
         else                       wdCnt <= wdCnt + WD_W'(1);
         if (timeout)         scanLostQ <= 1'b1;
         else if (publishNow) scanLostQ <= 1'b0;
      end
   end

   assign timeout   = (wdCnt == WD_W'(TIMEOUT_CYCLES));
   assign scan_lost = scanLostQ;
`else
   assign timeout   = 1'b0;
   assign scan_lost = 1'b0;
`endif

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Directed self-checking bench for ssd_scan_decoder. Expected publications
// are queued when a scan is driven and popped when frame_valid pulses.
// Build with SSD_DECODE_TIMEOUT_EN to also exercise the watchdog.
module tb_ssd_scan_decoder;

   typedef struct packed {
      logic [31:0] d;
      logic [7:0]  b;
   } frame_t;

   localparam logic [15:0][6:0] GLYPH = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  ssdAnode;
   logic [6:0]  ssdCathode;
   logic [31:0] digits;
   logic [7:0]  blank;
   logic        frame_valid, seg_err, anode_err, scan_lost;

   int     assertCount = 0;
   int     failCount = 0;
   int     pubCount = 0;
   int     segErrCount = 0;
   int     anodeErrCount = 0;
   int     expPub = 0;
   frame_t expQ[$];
   frame_t expFrame;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   ssd_scan_decoder #(
      .STABLE_FRAMES  (2),
      .TIMEOUT_CYCLES (64)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .ssdAnode    (ssdAnode),
      .ssdCathode  (ssdCathode),
      .digits      (digits),
      .blank       (blank),
      .frame_valid (frame_valid),
      .seg_err     (seg_err),
      .anode_err   (anode_err),
      .scan_lost   (scan_lost)
   );

   task automatic checkOutput(input string tag, input logic [39:0] observed,
                              input logic [39:0] expected);
      assertCount++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [7:0][6:0] cathFor(input logic [31:0] val);
      logic [7:0][6:0] c;
      for (int i = 0; i < 8; i++) c[i] = GLYPH[val[i*4 +: 4]];
      return c;
   endfunction

   // Drive one scan: each digit held 4 cycles then a 1-cycle gap. The gap
   // after digit glitchAfter becomes a two-digit anode with a junk cathode.
   task automatic applyStimulus(input logic [7:0][6:0] cath, input int glitchAfter,
                                input int nDigits);
      for (int d = 0; d < nDigits; d++) begin
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            ssdAnode   = ~(8'h01 << d);
            ssdCathode = cath[d];
         end
         @(negedge clk);
         if (d == glitchAfter) begin
            ssdAnode   = 8'hFC;
            ssdCathode = 7'h7E;
         end else begin
            ssdAnode   = 8'hFF;
            ssdCathode = 7'h7F;
         end
      end
   endtask

   // Output monitor, sampled just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (seg_err === 1'b1)   segErrCount++;
      if (anode_err === 1'b1) anodeErrCount++;
      if (frame_valid === 1'b1) begin
         pubCount++;
         checkOutput("publishExpected", 40'(expQ.size() != 0), 40'd1);
         if (expQ.size() != 0) begin
            expFrame = expQ.pop_front();
            checkOutput("publishDigits", 40'(digits), 40'(expFrame.d));
            checkOutput("publishBlank", 40'(blank), 40'(expFrame.b));
         end
      end
   end

   initial begin
      logic [7:0][6:0] cA, cB, cC, cD;
      int waitCycles;
      cA = cathFor(32'h0000_0123);
      cB = cathFor(32'h0000_0124);
      cC = cB;
      cC[7] = 7'h7F;
      cD = cathFor(32'h0000_0125);
      cD[7] = 7'h7E;

      reset      = 1'b1;
      ssdAnode   = 8'hFF;
      ssdCathode = 7'h7F;
      repeat (3) @(negedge clk);
      checkOutput("resetDigits", 40'(digits), 40'h0);
      checkOutput("resetBlank", 40'(blank), 40'hFF);
      checkOutput("resetFrameValid", 40'(frame_valid), 40'h0);
      checkOutput("resetSegErr", 40'(seg_err), 40'h0);
      checkOutput("resetAnodeErr", 40'(anode_err), 40'h0);
      checkOutput("resetScanLost", 40'(scan_lost), 40'h0);
      reset = 1'b0;

      $display("[TB] steady 0123 scan");
      expQ.push_back('{d: 32'h0000_0123, b: 8'h00});
      expPub++;
      repeat (3) applyStimulus(cA, -1, 8);
      checkOutput("firstPublishCount", 40'(pubCount), 40'(expPub));
      checkOutput("firstDigits", 40'(digits), 40'h0000_0123);
      checkOutput("firstBlank", 40'(blank), 40'h00);

      $display("[TB] alternating digit0 with an anode glitch");
      applyStimulus(cB, -1, 8);
      applyStimulus(cA, -1, 8);
      applyStimulus(cB, 3, 8);
      checkOutput("alternateNoPublish", 40'(pubCount), 40'(expPub));
      checkOutput("anodeErrPulses", 40'(anodeErrCount), 40'd1);
      checkOutput("glitchNoSegErr", 40'(segErrCount), 40'd0);
      checkOutput("digitsHeld", 40'(digits), 40'h0000_0123);
      expQ.push_back('{d: 32'h0000_0124, b: 8'h00});
      expPub++;
      repeat (2) applyStimulus(cB, -1, 8);
      checkOutput("secondPublishCount", 40'(pubCount), 40'(expPub));
      checkOutput("secondDigits", 40'(digits), 40'h0000_0124);

      $display("[TB] dark digit7 then illegal digit7");
      expQ.push_back('{d: 32'h0000_0124, b: 8'h80});
      expPub++;
      repeat (3) applyStimulus(cC, -1, 8);
      checkOutput("darkPublishCount", 40'(pubCount), 40'(expPub));
      checkOutput("darkBlank", 40'(blank), 40'h80);
      repeat (2) applyStimulus(cD, -1, 8);
      applyStimulus(cB, -1, 8);
      checkOutput("badNoPublish", 40'(pubCount), 40'(expPub));
      checkOutput("segErrPulses", 40'(segErrCount), 40'd2);
      checkOutput("badBlankHeld", 40'(blank), 40'h80);
      expQ.push_back('{d: 32'h0000_0124, b: 8'h00});
      expPub++;
      repeat (2) applyStimulus(cB, -1, 8);
      checkOutput("recoverPublishCount", 40'(pubCount), 40'(expPub));

`ifdef SSD_DECODE_TIMEOUT_EN
      $display("[TB] stalled scan with watchdog");
      waitCycles = 0;
      while (scan_lost !== 1'b1 && waitCycles < 200) begin
         @(negedge clk);
         waitCycles++;
      end
      checkOutput("scanLostSet", 40'(scan_lost), 40'h1);
      expQ.push_back('{d: 32'h0000_0124, b: 8'h00});
      expPub++;
      repeat (3) applyStimulus(cB, -1, 8);
      checkOutput("scanLostCleared", 40'(scan_lost), 40'h0);
      checkOutput("resumePublishCount", 40'(pubCount), 40'(expPub));
`else
      $display("[TB] stalled scan without watchdog");
      waitCycles = 100;
      repeat (waitCycles) @(negedge clk);
      checkOutput("stallScanLost", 40'(scan_lost), 40'h0);
      checkOutput("stallPublishCount", 40'(pubCount), 40'(expPub));
      checkOutput("stallDigitsHeld", 40'(digits), 40'h0000_0124);
`endif

      $display("[TB] reset in the middle of a frame");
      applyStimulus(cB, -1, 4);
      @(negedge clk);
      reset    = 1'b1;
      ssdAnode = 8'hFF;
      repeat (2) @(negedge clk);
      checkOutput("midResetDigits", 40'(digits), 40'h0);
      checkOutput("midResetBlank", 40'(blank), 40'hFF);
      checkOutput("midResetFrameValid", 40'(frame_valid), 40'h0);
      checkOutput("midResetScanLost", 40'(scan_lost), 40'h0);
      reset = 1'b0;
      applyStimulus(cA, -1, 8);
      applyStimulus(cA, -1, 8);
      checkOutput("afterResetOneFrameNoPublish", 40'(pubCount), 40'(expPub));
      expQ.push_back('{d: 32'h0000_0123, b: 8'h00});
      expPub++;
      applyStimulus(cA, -1, 8);
      checkOutput("afterResetPublishCount", 40'(pubCount), 40'(expPub));
      checkOutput("queueDrained", 40'(expQ.size()), 40'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
